// File: rtl/ex_issue_buffer.sv
// Execute-stage issue buffer: a small operand queue feeding a combinational ALU,
// followed by a single result register with a valid/ready writeback handshake.
package ex_issue_buffer_pkg;

    typedef logic [31:0] word;

    typedef enum logic [3:0] {
        alu_nop  = 4'd0,
        alu_add  = 4'd1,
        alu_sub  = 4'd2,
        alu_and  = 4'd3,
        alu_or   = 4'd4,
        alu_xor  = 4'd5,
        alu_sll  = 4'd6,
        alu_srl  = 4'd7,
        alu_sra  = 4'd8,
        alu_slt  = 4'd9,
        alu_sltu = 4'd10
    } aluop;

endpackage

module ex_issue_buffer
    import ex_issue_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,

    input  logic                         iss_valid_i,
    output logic                         iss_ready_o,
    input  word                          iss_data1_i,
    input  word                          iss_data2_i,
    input  aluop                         iss_op_i,
    input  logic [TAG_W-1:0]             iss_rd_i,

    output word                          ALU_data1_o,
    output word                          ALU_data2_o,
    output aluop                         ALU_op_o,
    input  word                          ALU_result_i,
    input  logic                         ALU_busy_i,

    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output word                          wb_result_o,
    output logic [TAG_W-1:0]             wb_rd_o,

    output logic [$clog2(DEPTH):0]       occ_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    typedef struct packed {
        word              data1;
        word              data2;
        aluop             op;
        logic [TAG_W-1:0] rd;
    } entry_t;

    entry_t             queue_q [DEPTH];
    entry_t             entry_d;
    entry_t             head_entry;

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               wb_valid_q, wb_valid_d;
    word                wb_result_q, wb_result_d;
    logic [TAG_W-1:0]   wb_rd_q, wb_rd_d;

    logic               not_empty;
    logic               iss_ready;
    logic               push;
    logic               fire;

    // Handshake qualifiers. Ready looks only at registered occupancy, so a
    // full queue refuses an issue even in a cycle where the head is popping.
    always_comb begin
        not_empty = (occ_q != '0);
        iss_ready = (occ_q < DEPTH_OCC);
        push      = iss_valid_i && iss_ready && !flush_i;
        fire      = not_empty && !ALU_busy_i && (!wb_valid_q || wb_ready_i) && !flush_i;
    end

    always_comb begin
        entry_d.data1 = iss_data1_i;
        entry_d.data2 = iss_data2_i;
        entry_d.op    = iss_op_i;
        entry_d.rd    = iss_rd_i;
        head_entry    = queue_q[head_q];
    end

    // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (fire) head_d = head_q + 1'b1;
            case ({push, fire})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Result register: a fire reloads it, a bare handshake empties it,
    // otherwise it holds so writeback sees stable data under backpressure.
    always_comb begin
        wb_valid_d  = wb_valid_q;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        if (flush_i) begin
            wb_valid_d = 1'b0;
        end else if (fire) begin
            wb_valid_d  = 1'b1;
            wb_result_d = ALU_result_i;
            wb_rd_d     = head_entry.rd;
        end else if (wb_ready_i) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_result_q <= '0;
            wb_rd_q     <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            wb_valid_q  <= wb_valid_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
        end
    end

    // NOTE: queue storage is deliberately not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_q[tail_q] <= entry_d;
        end
    end

    // The ALU sees the head entry only while something is queued.
    always_comb begin
        ALU_data1_o = '0;
        ALU_data2_o = '0;
        ALU_op_o    = alu_nop;
        if (not_empty) begin
            ALU_data1_o = head_entry.data1;
            ALU_data2_o = head_entry.data2;
            ALU_op_o    = head_entry.op;
        end
    end

    assign iss_ready_o = iss_ready;
    assign wb_valid_o  = wb_valid_q;
    assign wb_result_o = wb_result_q;
    assign wb_rd_o     = wb_rd_q;
    assign occ_o       = occ_q;

endmodule

// File: tb/tb_ex_issue_buffer.sv
// Directed bench for ex_issue_buffer (DEPTH=2): single op, backpressure, busy stall,
// pointer wrap at full throughput, flush and mid-stream reset.
module tb_ex_issue_buffer;
    import ex_issue_buffer_pkg::*;

    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic             iss_valid_i;
    logic             iss_ready_o;
    word              iss_data1_i;
    word              iss_data2_i;
    aluop             iss_op_i;
    logic [TAG_W-1:0] iss_rd_i;
    word              ALU_data1_o;
    word              ALU_data2_o;
    aluop             ALU_op_o;
    word              ALU_result_i;
    logic             ALU_busy_i;
    logic             wb_valid_o;
    logic             wb_ready_i;
    word              wb_result_o;
    logic [TAG_W-1:0] wb_rd_o;
    logic [$clog2(DEPTH):0] occ_o;

    int n_tests = 0;
    int n_fail  = 0;

    ex_issue_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .iss_valid_i  (iss_valid_i),
        .iss_ready_o  (iss_ready_o),
        .iss_data1_i  (iss_data1_i),
        .iss_data2_i  (iss_data2_i),
        .iss_op_i     (iss_op_i),
        .iss_rd_i     (iss_rd_i),
        .ALU_data1_o  (ALU_data1_o),
        .ALU_data2_o  (ALU_data2_o),
        .ALU_op_o     (ALU_op_o),
        .ALU_result_i (ALU_result_i),
        .ALU_busy_i   (ALU_busy_i),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_result_o  (wb_result_o),
        .wb_rd_o      (wb_rd_o),
        .occ_o        (occ_o)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational ALU.
    always_comb begin
        case (ALU_op_o)
            alu_add: ALU_result_i = ALU_data1_o + ALU_data2_o;
            alu_sub: ALU_result_i = ALU_data1_o - ALU_data2_o;
            default: ALU_result_i = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input word d1, input word d2, input aluop op, input int rd);
        iss_valid_i = 1'b1;
        iss_data1_i = d1;
        iss_data2_i = d2;
        iss_op_i    = op;
        iss_rd_i    = TAG_W'(rd);
    endtask

    task automatic idle();
        iss_valid_i = 1'b0;
        iss_data1_i = '0;
        iss_data2_i = '0;
        iss_op_i    = alu_nop;
        iss_rd_i    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        flush_i    = 1'b0;
        ALU_busy_i = 1'b0;
        wb_ready_i = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_occ",      occ_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_ready",    iss_ready_o, 1);
        check("rst_alu_op",   64'(ALU_op_o), 64'(alu_nop));
        check("rst_alu_d1",   ALU_data1_o, 0);
        check("rst_alu_d2",   ALU_data2_o, 0);
        check("rst_wb_res",   wb_result_o, 0);
        check("rst_wb_rd",    wb_rd_o, 0);

        // Single add: 5 + 7 -> 12, rd 3, two cycles after the push
        issue(32'd5, 32'd7, alu_add, 3);
        step();
        idle();
        check("add_occ1",   occ_o, 1);
        check("add_alu_op", 64'(ALU_op_o), 64'(alu_add));
        check("add_alu_d1", ALU_data1_o, 5);
        check("add_alu_d2", ALU_data2_o, 7);
        check("add_wb_n1",  wb_valid_o, 0);
        step();
        check("add_wb_valid", wb_valid_o, 1);
        check("add_wb_res",   wb_result_o, 12);
        check("add_wb_rd",    wb_rd_o, 3);
        check("add_occ0",     occ_o, 0);
        step();
        check("add_wb_drop",  wb_valid_o, 0);

        // Backpressure: three ops (1+1, 2+2, 3+3), writeback stalled
        wb_ready_i = 1'b0;
        issue(32'd1, 32'd1, alu_add, 1);
        step();
        issue(32'd2, 32'd2, alu_add, 2);
        step();
        check("bp_wb_valid1", wb_valid_o, 1);
        check("bp_wb_res1",   wb_result_o, 2);
        check("bp_ready_mid", iss_ready_o, 1);
        issue(32'd3, 32'd3, alu_add, 3);
        step();
        idle();
        check("bp_occ_full",  occ_o, 2);
        check("bp_not_ready", iss_ready_o, 0);
        check("bp_hold_res",  wb_result_o, 2);
        check("bp_hold_rd",   wb_rd_o, 1);
        step();
        check("bp_hold2_res", wb_result_o, 2);
        check("bp_hold2_vld", wb_valid_o, 1);
        check("bp_hold2_occ", occ_o, 2);
        wb_ready_i = 1'b1;
        step();
        check("bp_res2", wb_result_o, 4);
        check("bp_rd2",  wb_rd_o, 2);
        check("bp_occ1", occ_o, 1);
        step();
        check("bp_res3",  wb_result_o, 6);
        check("bp_rd3",   wb_rd_o, 3);
        check("bp_vld3",  wb_valid_o, 1);
        check("bp_occ0",  occ_o, 0);
        step();
        check("bp_drain", wb_valid_o, 0);

        // Busy stall: 9 - 4 held at the ALU for three cycles
        ALU_busy_i = 1'b1;
        issue(32'd9, 32'd4, alu_sub, 7);
        step();
        idle();
        for (int c = 0; c < 3; c++) begin
            check("busy_d1", ALU_data1_o, 9);
            check("busy_d2", ALU_data2_o, 4);
            check("busy_op", 64'(ALU_op_o), 64'(alu_sub));
            check("busy_wb", wb_valid_o, 0);
            if (c < 2) step();
        end
        step();
        ALU_busy_i = 1'b0;
        check("busy_wb_low", wb_valid_o, 0);
        step();
        check("busy_wb_vld", wb_valid_o, 1);
        check("busy_wb_res", wb_result_o, 5);
        check("busy_wb_rd",  wb_rd_o, 7);
        step();
        check("busy_done", wb_valid_o, 0);

        // Wrap: ten back-to-back ops i + 100, rd = i
        for (int c = 0; c < 12; c++) begin
            if (c < 10) begin
                check("wrap_ready", iss_ready_o, 1);
                issue(word'(c), 32'd100, alu_add, c);
            end else begin
                idle();
            end
            if (c >= 2) begin
                check("wrap_vld", wb_valid_o, 1);
                check("wrap_rd",  wb_rd_o, 64'(c - 2));
                check("wrap_res", wb_result_o, 64'(c - 2 + 100));
            end
            step();
        end
        check("wrap_end_vld", wb_valid_o, 0);
        check("wrap_end_occ", occ_o, 0);

        // Flush with the queue full and a result pending
        wb_ready_i = 1'b0;
        issue(32'd1, 32'd2, alu_add, 10);
        step();
        issue(32'd3, 32'd4, alu_add, 11);
        step();
        issue(32'd5, 32'd6, alu_add, 12);
        step();
        check("fl_pre_occ", occ_o, 2);
        check("fl_pre_vld", wb_valid_o, 1);
        flush_i = 1'b1;
        issue(32'd7, 32'd8, alu_add, 13);
        step();
        flush_i = 1'b0;
        idle();
        wb_ready_i = 1'b1;
        check("fl_occ",   occ_o, 0);
        check("fl_vld",   wb_valid_o, 0);
        check("fl_ready", iss_ready_o, 1);
        check("fl_op",    64'(ALU_op_o), 64'(alu_nop));
        step();
        check("fl_quiet1", wb_valid_o, 0);
        check("fl_quiet_occ", occ_o, 0);

        // Flush with one queued op and an offered push: both are dropped
        issue(32'd20, 32'd1, alu_add, 14);
        step();
        check("fl2_occ1", occ_o, 1);
        flush_i = 1'b1;
        issue(32'd30, 32'd1, alu_add, 15);
        step();
        flush_i = 1'b0;
        idle();
        check("fl2_occ0", occ_o, 0);
        check("fl2_vld",  wb_valid_o, 0);
        step();
        check("fl2_quiet", wb_valid_o, 0);

        // Reset mid-stream with two ops queued and the ALU busy
        ALU_busy_i = 1'b1;
        issue(32'd40, 32'd2, alu_add, 20);
        step();
        issue(32'd50, 32'd3, alu_add, 21);
        step();
        idle();
        check("rs_pre_occ", occ_o, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ALU_busy_i = 1'b0;
        check("rs_occ",   occ_o, 0);
        check("rs_vld",   wb_valid_o, 0);
        check("rs_res",   wb_result_o, 0);
        check("rs_rd",    wb_rd_o, 0);
        check("rs_op",    64'(ALU_op_o), 64'(alu_nop));
        check("rs_ready", iss_ready_o, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rs_quiet", wb_valid_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_issue_buffer.md
EX_ISSUE_BUFFER -- requirements
Module: ex_issue_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of operand-queue entries (legal 2..8, power of two).
REQ-002 The block SHALL have parameter TAG_W, default 5, meaning the destination-register tag width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port flush_i, input, 1 bit: discard all queued and completed operations.
REQ-006 The block SHALL have port iss_valid_i, input, 1 bit: the issue side offers an operation.
REQ-007 The block SHALL have port iss_ready_o, output, 1 bit: the queue accepts an operation.
REQ-008 The block SHALL have ports iss_data1_i and iss_data2_i, inputs, word (32 bits): the operands.
REQ-009 The block SHALL have port iss_op_i, input, aluop: the ALU operation.
REQ-010 The block SHALL have port iss_rd_i, input, TAG_W bits: the destination tag.
REQ-011 The block SHALL have ports ALU_data1_o and ALU_data2_o, outputs, word: the head-entry operands driven to the ALU.
REQ-012 The block SHALL have port ALU_op_o, output, aluop: the head-entry operation, or alu_nop when the queue is empty.
REQ-013 The block SHALL have port ALU_result_i, input, word: the combinational ALU result.
REQ-014 The block SHALL have port ALU_busy_i, input, 1 bit: the ALU result is not yet valid this cycle.
REQ-015 The block SHALL have port wb_valid_o, output, 1 bit: the result register holds a completed operation.
REQ-016 The block SHALL have port wb_ready_i, input, 1 bit: writeback consumes the result.
REQ-017 The block SHALL have ports wb_result_o (word) and wb_rd_o (TAG_W), outputs: the completed result and its tag.
REQ-018 The block SHALL have port occ_o, output, clog2(DEPTH)+1 bits: the current queue occupancy.

Function
REQ-019 Push SHALL occur when iss_valid_i && iss_ready_o && !flush_i; the entry {data1, data2, op, rd} is written at the tail and the tail pointer wraps modulo DEPTH.
REQ-020 iss_ready_o SHALL equal (occ_o < DEPTH) and SHALL depend only on registered state; there is no same-cycle pop-to-push pass-through.
REQ-021 When occ_o > 0, ALU_data1_o, ALU_data2_o and ALU_op_o SHALL be driven combinationally from the head entry; when occ_o = 0 they SHALL be 0, 0 and alu_nop.
REQ-022 A fire condition SHALL be defined as occ_o > 0 && !ALU_busy_i && (!wb_valid_o || wb_ready_i).
REQ-023 On fire, the block SHALL capture ALU_result_i and the head tag into the result register, set wb_valid_o, and pop the head (head pointer wraps modulo DEPTH).
REQ-024 A wb handshake without a same-cycle fire SHALL clear wb_valid_o; a handshake with a fire SHALL reload the register with wb_valid_o remaining 1.
REQ-025 While wb_valid_o = 1 and wb_ready_i = 0, wb_result_o and wb_rd_o SHALL be held stable.
REQ-026 A same-cycle push and pop SHALL leave occ_o unchanged; occ_o SHALL never exceed DEPTH nor underflow.
REQ-027 Latency SHALL be 2 cycles: a push in cycle N with no stalls gives wb_valid_o = 1 in cycle N+2.
REQ-028 Throughput SHALL be one operation per cycle when ALU_busy_i = 0 and wb_ready_i = 1.
REQ-029 While ALU_busy_i = 1, the head entry SHALL be held and its ALU outputs SHALL remain stable.
REQ-030 flush_i SHALL, at the next edge, empty the queue (occ_o = 0, pointers = 0), clear wb_valid_o, and suppress any same-cycle push and fire.

Reset
REQ-031 On rst = 1 at a clock edge, occ_o, the head and tail pointers, wb_valid_o, wb_result_o and wb_rd_o SHALL all become 0, and ALU outputs SHALL read 0/0/alu_nop.
REQ-032 rst SHALL take priority over flush_i, push and fire, and SHALL abort in-flight operations without producing a wb_valid_o pulse.
REQ-033 Queue storage contents SHALL NOT need to be reset.

Verification
REQ-034 Single add: push {5, 7, alu_add, rd=3}, with ALU_result_i = 12 and wb_ready_i = 1 -> wb_valid_o = 1 two cycles later with result 12, rd 3, then occ_o = 0.
REQ-035 Backpressure: wb_ready_i = 0 and push 3 ops with DEPTH = 2 -> the result register holds op1; after both remaining ops are queued, occ_o = 2 and iss_ready_o = 0; releasing wb_ready_i drains the results in order 1, 2, 3.
REQ-036 Busy stall: push alu_sub {9, 4} with ALU_busy_i = 1 for 3 cycles -> ALU outputs stay {9, 4, alu_sub}; wb_valid_o rises the cycle after busy drops, with result 5.
REQ-037 Wrap: stream 10 back-to-back ops with distinct rd values 0..9 at full throughput -> results appear in order one per cycle and the pointers wrap without loss.
REQ-038 Flush: with queue full and wb_valid_o = 1, assert flush_i together with iss_valid_i -> next cycle occ_o = 0 and wb_valid_o = 0, and the flushed op never appears.
REQ-039 Reset mid-stream: assert rst while occ_o = 2 and ALU_busy_i = 1 -> next cycle all outputs are at their reset values, and no stale result appears afterwards.
